// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock frequency monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2
    } mon_state_t;

    localparam int WINDOW_DEF  = 1000;
    localparam int CNT_W_DEF   = 16;
    localparam int EXP_MIN_DEF = 228;
    localparam int EXP_MAX_DEF = 232;
    localparam int LOCK_N_DEF  = 4;
    // Cycles spent filling the synchronizer before edges are trusted
    localparam int WARMUP_LEN  = 3;

endpackage

// File: rtl/mon_edge_sync.sv
// Two-flop synchronizer for the monitored clock followed by a registered
// rising-edge detector; edge_pulse lags the input by 3 clk cycles.
module mon_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            sync_prev  <= sync_2;
            edge_pulse <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of mon_clk over back-to-back WINDOW-cycle gates and
// reports the count, range check, stuck detection and lock status.
//
// state   | meaning
// IDLE    | disabled, waiting for en
// WARMUP  | synchronizer fill, edges ignored for WARMUP_LEN cycles
// MEASURE | gating window running, counting edges
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int WINDOW  = WINDOW_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int EXP_MIN = EXP_MIN_DEF,
    parameter int EXP_MAX = EXP_MAX_DEF,
    parameter int LOCK_N  = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             in_range,
    output logic             stuck,
    output logic             lock
);

    localparam int LC_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(EXP_MAX);
    localparam logic [LC_W-1:0]  LOCK_TGT  = LC_W'(LOCK_N);
    localparam logic [1:0]       WARM_LAST = 2'(WARMUP_LEN - 1);

    mon_state_t       state;
    logic [1:0]       warm_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [LC_W-1:0]  consec;

    logic             edge_pulse;
    logic [CNT_W-1:0] closing_cnt;
    logic             closing_in_range;
    logic [LC_W-1:0]  consec_next;

    mon_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (mon_clk),
        .edge_pulse (edge_pulse)
    );

    // Edge count including this cycle's edge, so a boundary edge closes with its window
    always_comb begin
        closing_cnt = edge_cnt;
        if (edge_pulse && (edge_cnt != '1)) begin
            closing_cnt = edge_cnt + CNT_W'(1);
        end
        closing_in_range = (closing_cnt >= CNT_MIN) && (closing_cnt <= CNT_MAX);
        consec_next = '0;
        if (closing_in_range) begin
            consec_next = (consec == LOCK_TGT) ? consec : consec + LC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            warm_cnt <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            consec   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            in_range <= 1'b0;
            stuck    <= 1'b0;
            lock     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state    <= WARMUP;
                        warm_cnt <= '0;
                    end
                end
                WARMUP: begin
                    if (!en) begin
                        state    <= IDLE;
                        warm_cnt <= '0;
                        consec   <= '0;
                        lock     <= 1'b0;
                    end else if (warm_cnt == WARM_LAST) begin
                        state    <= MEASURE;
                        warm_cnt <= '0;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        // Partial window is dropped; reported results stay as they were
                        state    <= IDLE;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        consec   <= '0;
                        lock     <= 1'b0;
                    end else if (win_cnt == WIN_LAST) begin
                        count    <= closing_cnt;
                        valid    <= 1'b1;
                        in_range <= closing_in_range;
                        stuck    <= (closing_cnt == '0);
                        consec   <= consec_next;
                        lock     <= (consec_next == LOCK_TGT);
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        win_cnt  <= win_cnt + CNT_W'(1);
                        edge_cnt <= closing_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a scoreboard of expected window results.
module tb_clk_freq_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mon_clk;
    logic [15:0] count;
    logic        valid;
    logic        in_range;
    logic        stuck;
    logic        lock;

    logic mon_gen;
    logic mon_man;
    logic mon_run;
    int   mon_half;

    typedef struct {
        logic [15:0] cnt;
        bit          chk_cnt;
        bit          rng;
        bit          stk;
        bit          lck;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   lat;

    assign mon_clk = mon_run ? mon_gen : mon_man;

    clk_freq_monitor #(
        .WINDOW  (100),
        .CNT_W   (16),
        .EXP_MIN (24),
        .EXP_MAX (26),
        .LOCK_N  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mon_clk  (mon_clk),
        .count    (count),
        .valid    (valid),
        .in_range (in_range),
        .stuck    (stuck),
        .lock     (lock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitored clock toggles at 2 mod 10, never coincident with a clk edge
    initial begin
        mon_gen = 1'b0;
        #2;
        forever begin
            #(mon_half) mon_gen = ~mon_gen;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input bit cc, input bit r, input bit s, input bit l);
        exp_t e;
        e.cnt     = 16'(c);
        e.chk_cnt = cc;
        e.rng     = r;
        e.stk     = s;
        e.lck     = l;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc, output int lt);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        lt   = 0;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                seen = 1'b1;
                lt   = i;
            end
        end
        chk({tag, ".seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_cnt) chk({tag, ".count"}, 32'(count), 32'(e.cnt));
                chk({tag, ".in_range"}, 32'(in_range), 32'(e.rng));
                chk({tag, ".stuck"}, 32'(stuck), 32'(e.stk));
                chk({tag, ".lock"}, 32'(lock), 32'(e.lck));
            end
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int nv;
        nv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        chk(tag, 32'(nv), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        mon_man  = 1'b0;
        mon_run  = 1'b1;
        mon_half = 20;

        // Reset state
        @(negedge clk);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.in_range", 32'(in_range), 32'd0);
        chk("rst.stuck", 32'(stuck), 32'd0);
        chk("rst.lock", 32'(lock), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 40 ns monitored clock: 25 edges per window, lock on the third
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 1);
        en = 1'b1;
        wait_valid("w1", 200, lat);
        chk("w1.latency", 32'(lat), 32'd104);
        @(negedge clk);
        chk("w1.pulse_width", 32'(valid), 32'd0);
        wait_valid("w2", 200, lat);
        chk("w2.period", 32'(lat), 32'd99);
        wait_valid("w3", 200, lat);
        chk("w3.period", 32'(lat), 32'd100);

        // Abort at window cycle 50
        quiet("pre_abort", 50);
        en = 1'b0;
        @(negedge clk);
        chk("abort.lock", 32'(lock), 32'd0);
        chk("abort.count_hold", 32'(count), 32'd25);
        chk("abort.in_range_hold", 32'(in_range), 32'd1);
        chk("abort.stuck_hold", 32'(stuck), 32'd0);
        quiet("abort.no_valid", 150);

        // Re-enable, relock, then double the monitored frequency
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 1);
        en = 1'b1;
        wait_valid("re1", 200, lat);
        chk("re1.latency", 32'(lat), 32'd104);
        wait_valid("re2", 200, lat);
        wait_valid("re3", 200, lat);
        mon_half = 10;
        push(0, 0, 0, 0, 0);
        push(50, 1, 0, 0, 0);
        wait_valid("mixed", 200, lat);
        wait_valid("fast", 200, lat);
        chk("fast.period", 32'(lat), 32'd100);

        // Stuck monitored clock
        en      = 1'b0;
        mon_run = 1'b0;
        mon_man = 1'b0;
        quiet("stuck.idle", 10);
        push(0, 1, 0, 1, 0);
        push(0, 1, 0, 1, 0);
        en = 1'b1;
        wait_valid("stuck1", 200, lat);
        chk("stuck1.latency", 32'(lat), 32'd104);
        wait_valid("stuck2", 200, lat);

        // Single edge landing on the last window cycle
        push(1, 1, 0, 0, 0);
        repeat (96) @(posedge clk);
        #2 mon_man = 1'b1;
        wait_valid("edge_c99", 200, lat);

        // Single edge landing on the first cycle of the following window
        push(0, 1, 0, 1, 0);
        push(1, 1, 0, 0, 0);
        repeat (40) @(posedge clk);
        #2 mon_man = 1'b0;
        repeat (57) @(posedge clk);
        #2 mon_man = 1'b1;
        wait_valid("edge_c0.prev", 200, lat);
        wait_valid("edge_c0.next", 200, lat);

        // Asynchronous reset mid-window while locked
        en       = 1'b0;
        mon_run  = 1'b1;
        mon_half = 20;
        @(negedge clk);
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 0);
        push(25, 1, 1, 0, 1);
        en = 1'b1;
        wait_valid("pr1", 200, lat);
        wait_valid("pr2", 200, lat);
        wait_valid("pr3", 200, lat);
        quiet("pre_rst", 40);
        #3 rst = 1'b1;
        #1;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.in_range", 32'(in_range), 32'd0);
        chk("arst.stuck", 32'(stuck), 32'd0);
        chk("arst.lock", 32'(lock), 32'd0);
        quiet("arst.no_valid", 80);
        rst = 1'b0;
        push(25, 1, 1, 0, 0);
        wait_valid("post_rst", 200, lat);
        chk("post_rst.latency", 32'(lat), 32'd104);

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_freq_monitor.md
CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 The module SHALL have parameter WINDOW, default 1000, giving the gate length in clk cycles (10 us at 100 MHz).
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the edge-count width; WINDOW SHALL be < 2^CNT_W.
REQ-003 The module SHALL have parameter EXP_MIN, default 228, giving the lowest in-range count inclusive (23 MHz cpu clock, -2).
REQ-004 The module SHALL have parameter EXP_MAX, default 232, giving the highest in-range count inclusive.
REQ-005 The module SHALL have parameter LOCK_N, default 4, giving the number of consecutive in-range windows needed to assert lock.
REQ-006 The module SHALL have port: clk  in  1  board reference clock, sole clock domain, all logic on rising edge.
REQ-007 The module SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-008 The module SHALL have port: en  in  1  measurement enable, synchronous to clk.
REQ-009 The module SHALL have port: mon_clk  in  1  monitored clock (e.g. CPU clock-wizard output), treated as asynchronous data and never used as a clock.
REQ-010 The module SHALL have port: count  out  CNT_W  rising-edge count of the last completed window.
REQ-011 The module SHALL have port: valid  out  1  one-cycle pulse when count updates.
REQ-012 The module SHALL have port: in_range  out  1  last count within [EXP_MIN, EXP_MAX].
REQ-013 The module SHALL have port: stuck  out  1  last window saw zero edges.
REQ-014 The module SHALL have port: lock  out  1  LOCK_N consecutive in-range windows.

Function
REQ-015 mon_clk SHALL pass through a 2-flop synchronizer followed by a registered rising-edge detector; total edge-detect latency is 3 clk cycles; mon_clk frequency SHALL be below clk/2 for correct counting.
REQ-016 The FSM SHALL have three states: IDLE, WARMUP, MEASURE.
REQ-017 The FSM SHALL go from IDLE to WARMUP on en=1; WARMUP SHALL last 3 cycles (synchronizer fill, edges ignored) and then go to MEASURE with window and edge counters at 0.
REQ-018 In MEASURE the window counter SHALL increment each cycle from 0 to WINDOW-1, and the edge counter SHALL increment on each detected edge, saturating at 2^CNT_W-1.
REQ-019 On the cycle the window counter equals WINDOW-1, count SHALL be registered as edge_cnt plus that cycle's edge, so an edge on the boundary cycle belongs to the closing window.
REQ-020 valid, in_range and stuck SHALL update in the same register stage as count, with valid high for exactly the next cycle.
REQ-021 Both counters SHALL restart at 0 on the following cycle with no gap, so windows are back-to-back and valid recurs every WINDOW cycles.
REQ-022 The consecutive-in-range counter SHALL increment per in-range window (saturating at LOCK_N); lock SHALL be 1 while this counter equals LOCK_N.
REQ-023 Any out-of-range or stuck window SHALL clear the consecutive-in-range counter and deassert lock in the same cycle that valid is asserted.
REQ-024 Deasserting en in WARMUP or MEASURE SHALL abort to IDLE next cycle: the partial window is discarded, no valid is issued, lock and the consecutive counter clear, and count/in_range/stuck hold their last values.
REQ-025 Re-asserting en SHALL restart from WARMUP.
REQ-026 en asserted in IDLE on the same cycle an edge is detected SHALL NOT count that edge.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE; all counters 0; count 0; valid 0; in_range 0; stuck 0; lock 0; synchronizer and edge flops 0.
REQ-028 Release of rst SHALL take effect on a clk edge; the first window completes no earlier than 3+WINDOW cycles after en is seen.
REQ-029 Reset mid-window SHALL discard the window with no valid pulse.

Structure
REQ-030 A shared package clk_mon_pkg SHALL hold the state enum (IDLE/WARMUP/MEASURE), the default WINDOW/EXP_MIN/EXP_MAX/LOCK_N constants and the warm-up length 3.
REQ-031 One sub-module, mon_edge_sync, SHALL implement the 2-flop synchronizer plus edge detector, with ports clk, rst, async_in, and edge_pulse.
REQ-032 The range comparisons and lock logic SHALL stay in the top module.

Verification (WINDOW=100, EXP_MIN=24, EXP_MAX=26, LOCK_N=3, clk 10 ns)
REQ-033 mon_clk with a 40 ns period and en held high -> valid every 100 cycles, count=25 (+/-1 depending on phase), in_range=1, lock=1 at the third valid.
REQ-034 mon_clk held at 0 -> count=0, stuck=1, in_range=0, lock=0 at every valid.
REQ-035 mon_clk period changed from 40 ns to 20 ns after lock -> next count=50, in_range=0, lock drops in the same cycle as valid.
REQ-036 en dropped at window cycle 50 then re-raised -> no valid for the aborted window, count holds its old value, lock=0, first new valid 103 cycles after re-enable.
REQ-037 rst pulsed mid-window (asynchronous, not aligned to clk) -> all outputs 0 immediately, no valid issued, normal operation resumes after release.
REQ-038 Edge detected exactly on window cycle 99 -> counted in the closing window (count includes it), next window starts at 0.
